// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception controller (M stage): SR/Cause/EPC, mfc0/mtc0,
// exception/interrupt request generation and eret EXL clear.
module cp0_exc_ctrl #(
    parameter int unsigned HWINT_W  = 6,
    parameter logic [31:0] SR_WMASK = 32'h0000_FC03
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [4:0]         CP0Add,
    input  logic [31:0]        CP0In,
    input  logic [31:0]        VPC,
    input  logic               BDIn,
    input  logic [4:0]         ExcCodeIn,
    input  logic [HWINT_W-1:0] HWInt,
    input  logic               EXLClr,
    output logic [31:0]        CP0Out,
    output logic [31:0]        EPCOut,
    output logic               Req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;

    logic [31:0] sr_q, sr_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [4:0]  exc_code;
    logic [31:0] victim_pc;

    assign int_req   = (|(HWInt & sr_q[10 +: HWINT_W])) & sr_q[0] & ~sr_q[1];
    assign exc_req   = (ExcCodeIn != 5'd0) & ~sr_q[1];
    assign req       = int_req | exc_req;
    assign exc_code  = int_req ? 5'd0 : ExcCodeIn;
    assign victim_pc = BDIn ? (VPC - 32'd4) : VPC;

    // Registers are already cleared while reset is low; only Req needs gating
    // because ExcCodeIn can be nonzero during reset.
    assign Req    = req & reset;
    assign EPCOut = epc_q;

    always_comb begin
        sr_d    = sr_q;
        cause_d = cause_q;
        epc_d   = epc_q;

        cause_d[10 +: HWINT_W] = HWInt;

        if (req) begin
            sr_d[1]       = 1'b1;
            cause_d[31]   = BDIn;
            cause_d[6:2]  = exc_code;
            epc_d         = {victim_pc[31:2], 2'b00};
        end else if (en) begin
            if (CP0Add == ADDR_SR) begin
                sr_d = (CP0In & SR_WMASK) | (sr_q & ~SR_WMASK);
            end else if (CP0Add == ADDR_EPC) begin
                epc_d = {CP0In[31:2], 2'b00};
            end
        end

        // eret clear is applied last so it overrides an mtc0 to SR in the same cycle.
        if (EXLClr) begin
            sr_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        CP0Out = '0;
        case (CP0Add)
            ADDR_SR:    CP0Out = sr_q;
            ADDR_CAUSE: CP0Out = cause_q;
            ADDR_EPC:   CP0Out = epc_q;
            default:    CP0Out = '0;
        endcase
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception controller in the M stage of the five-stage MIPS pipeline.
- Produces the `Req` and `EPC` signals that the fetch unit consumes: `Req` flushes and redirects fetch to the handler, and `EPC` is the return target fetch uses on `eret`.
- Holds SR (reg 12), Cause (reg 13) and EPC (reg 14). It serves `mfc0`/`mtc0`, latches exception/interrupt state, and clears EXL on `eret`.

Parameters:
- `HWINT_W`, 6, number of hardware interrupt lines (maps to IM/IP bits 15:10).
- `SR_WMASK`, 32'h0000_FC03, writable SR bits: IM[15:10], EXL[1], IE[0].

Ports:
- `clk` input 1: system clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; when low, all registers cleared immediately.
- `en` input 1: `mtc0` write enable (M-stage instruction is `mtc0`).
- `CP0Add` input 5: register index for `mfc0`/`mtc0`.
- `CP0In` input 32: `mtc0` write data.
- `VPC` input 32: PC of the M-stage (victim) instruction.
- `BDIn` input 1: victim is in a branch delay slot.
- `ExcCodeIn` input 5: pipelined exception code of the victim; 0 = none.
- `HWInt` input `HWINT_W`: external interrupt lines (level).
- `EXLClr` input 1: M-stage instruction is `eret`.
- `CP0Out` output 32: `mfc0` read data.
- `EPCOut` output 32: current EPC register, to fetch.
- `Req` output 1: take exception/interrupt this cycle.

Behaviour:
- **Reset** (`reset`=0, async):
  - SR=0, Cause=0, EPC=0.
  - `Req` forced 0 while `reset` low; `CP0Out`=0; `EPCOut`=0.
- **Interrupt qualification:**
  - `IntReq` = (|(`HWInt` & SR.IM)) & SR.IE & ~SR.EXL.
  - `ExcReq` = (`ExcCodeIn`!=0) & ~SR.EXL.
  - `Req` = `IntReq` | `ExcReq`, combinational from current registers and inputs.
- **Priority:** interrupt over exception. Recorded ExcCode = `IntReq` ? 0 : `ExcCodeIn`.
- **On rising edge with `Req`=1:**
  - SR.EXL<=1.
  - Cause.ExcCode[6:2]<=recorded code.
  - Cause.BD[31]<=`BDIn`.
  - EPC<= `BDIn` ? (`VPC` - 4) : `VPC`, with bits [1:0] forced 0.
- **`Req` vs `mtc0`:** `Req` and `en` in the same cycle means the `mtc0` is dropped; the victim did not commit.
- **`mtc0`** (`en`=1, `Req`=0):
  - Addr 12: SR <= (`CP0In` & `SR_WMASK`) | (SR & ~`SR_WMASK`).
  - Addr 14: EPC <= {`CP0In`[31:2], 2'b00}.
  - Addr 13 and all other addresses: no write.
- **`eret`** (`EXLClr`=1): SR.EXL<=0 at the edge.
  - `EXLClr` with `Req` cannot both be active, because `eret` only executes with EXL=1, which masks `Req`.
  - If `EXLClr` and `en` to SR occur in the same cycle, EXL is cleared last, so the `eret` clear wins on bit 1.
- **Cause.IP[15:10]** <= `HWInt` every edge, regardless of EXL or `Req`. It is the only Cause field updated outside an exception.
- **`mfc0`:** `CP0Out` is combinational on `CP0Add`.
  - 12 reads SR, 13 reads Cause, 14 reads EPC; other addresses read 0.
  - Reads return pre-edge values; there is no write-through bypass.
- **`EPCOut`** = EPC register, no bypass. The hazard unit stalls `eret` in D while an `mtc0` to reg 14 is in E or M.
- Unimplemented SR/Cause bits read 0.
- Widths are 32-bit unsigned. `VPC`-4 wraps modulo 2^32 (`VPC`=0 gives EPC=32'hFFFF_FFFC).

Test Plan:
- Reset low mid-run with SR=32'h0000_FC03, EPC=32'h0000_3010 -> all registers read 0 immediately, before the next edge; `Req`=0.
- SR=32'h0000_0401, `HWInt`=6'b000001, `VPC`=32'h0000_3008, `BDIn`=0 -> `Req`=1 same cycle.
  - Next cycle: EPC=32'h0000_3008, Cause.ExcCode=0, SR.EXL=1, `Req`=0.
- SR=0, `ExcCodeIn`=5'd12, `VPC`=32'h0000_3020, `BDIn`=1 -> `Req`=1.
  - After edge: EPC=32'h0000_301C, Cause=32'h8000_0030 (BD=1, ExcCode=12).
- Simultaneous `ExcCodeIn`=5'd10 and enabled `HWInt`[2] with IM[12]=1, IE=1 -> recorded ExcCode=0; same cycle `en`=1, `CP0Add`=12 write ignored.
- EXL=1, `ExcCodeIn`=5'd4 -> `Req`=0, no register change. Then `EXLClr`=1 -> SR.EXL=0 next cycle and `EPCOut` unchanged.
- `mtc0` addr 14 data 32'h0000_4003 -> EPC=32'h0000_4000.
  - `mtc0` addr 13 data 32'hFFFF_FFFF -> Cause unchanged.
  - `mfc0` addr 7 -> `CP0Out`=0.
